// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T-FF bounded up-counter: state encoding and
// the supported bank width range.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } tff_state_e;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 16;

    function automatic bit width_legal(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop storage cell with synchronous active-high clear.
module tff_cell (
    input  logic clk,
    input  logic clear,
    input  logic t,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequences a bank of T-FF cells as a bounded synchronous up-counter with
// start/pause/stop control and a one-cycle done pulse.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("tff_counter_ctrl: WIDTH out of range");
    end

    tff_state_e       state_q;
    logic [WIDTH-1:0] limit_q;
    logic             done_q;
    logic             busy_q;

    logic             start_acc;
    logic             inc_en;
    logic             cell_clear;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] qbar;

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign cell_clear = clear || start_acc;
    assign inc_en     = (state_q == ST_RUN) && !pause && !stop && (count != limit_q);

    // Ripple-carry toggle chain: cell i flips only when all lower cells are 1.
    always_comb begin
        toggle    = '0;
        toggle[0] = inc_en;
        for (int i = 1; i < int'(WIDTH); i++) begin
            toggle[i] = toggle[i-1] && !qbar[i-1];
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .clear (cell_clear),
            .t     (toggle[i]),
            .q     (count[i]),
            .qbar  (qbar[i])
        );
    end

    // done and busy are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        limit_q <= limit;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (pause) begin
                        state_q <= ST_HOLD;
                        busy_q  <= 1'b1;
                    end else if (count == limit_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (!pause) begin
                            state_q <= ST_RUN;
                        end
                        busy_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl: directed scenarios followed by
// randomized control traffic, all compared against a behavioural model.
module tb_tff_counter_ctrl;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] limit;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    tff_counter_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .limit (limit),
        .pause (pause),
        .stop  (stop),
        .count (count),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc_n;
    int done_pulses;
    int done_cyc;
    int s_cyc;

    // Reference model: mode 0=idle 1=run 2=hold 3=done, plain integers.
    int m_mode;
    int m_count;
    int m_limit;
    int m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic model_step(input logic st, input int lim, input logic pa, input logic sp,
                              input logic cl);
        if (cl) begin
            m_mode  = 0;
            m_count = 0;
            m_limit = 0;
        end else begin
            case (m_mode)
                0: if (st) begin
                    m_limit = lim;
                    m_count = 0;
                    m_mode  = 1;
                end
                1: begin
                    if (sp)                    m_mode = 0;
                    else if (pa)               m_mode = 2;
                    else if (m_count == m_limit) m_mode = 3;
                    else                       m_count = m_count + 1;
                end
                2: begin
                    if (sp)       m_mode = 0;
                    else if (!pa) m_mode = 1;
                end
                default: m_mode = 0;
            endcase
        end
        m_done = (m_mode == 3) ? 1 : 0;
    endtask

    task automatic tick(input logic st, input logic [WIDTH-1:0] lim, input logic pa,
                        input logic sp, input logic cl);
        start = st;
        limit = lim;
        pause = pa;
        stop  = sp;
        clear = cl;
        @(posedge clk);
        model_step(st, int'(lim), pa, sp, cl);
        #1;
        cyc_n++;
        check("count", 32'(count), 32'(m_count));
        check("state", 32'(state), 32'(m_mode));
        check("busy", 32'(busy), 32'((m_mode == 1 || m_mode == 2) ? 1 : 0));
        check("done", 32'(done), 32'(m_done));
        if (done) begin
            done_pulses++;
            done_cyc = cyc_n;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input logic [WIDTH-1:0] lim);
        done_pulses = 0;
        tick(1'b1, lim, 1'b0, 1'b0, 1'b0);
        s_cyc = cyc_n;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc_n    = 0;
        m_mode   = 0;
        m_count  = 0;
        m_limit  = 0;
        m_done   = 0;
        done_pulses = 0;
        done_cyc = 0;
        s_cyc    = 0;

        // Reset with a start request that must not be accepted.
        tick(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        idle(1);

        // Basic run to 5.
        go(4'd5);
        idle(9);
        check("s2_pulses", 32'(done_pulses), 32'd1);
        check("s2_latency", 32'(done_cyc - s_cyc), 32'd6);
        check("s2_hold", 32'(count), 32'd5);

        // Pause for 3 cycles at count 2.
        go(4'd5);
        idle(2);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(12);
        check("s3_pulses", 32'(done_pulses), 32'd1);
        check("s3_latency", 32'(done_cyc - s_cyc), 32'd10);

        // Full range.
        go(4'd15);
        idle(20);
        check("s4_pulses", 32'(done_pulses), 32'd1);
        check("s4_hold", 32'(count), 32'd15);

        // Abort with stop+pause at count 3, then zero limit.
        go(4'd7);
        idle(3);
        tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("s5_abort_pulses", 32'(done_pulses), 32'd0);
        check("s5_abort_count", 32'(count), 32'd3);
        go(4'd0);
        idle(4);
        check("s5_zero_pulses", 32'(done_pulses), 32'd1);
        check("s5_zero_latency", 32'(done_cyc - s_cyc), 32'd1);
        check("s5_zero_count", 32'(count), 32'd0);

        // Start mid-run is ignored; then clear mid-run.
        go(4'd9);
        idle(2);
        tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(10);
        check("s6_pulses", 32'(done_pulses), 32'd1);
        check("s6_final", 32'(count), 32'd9);
        go(4'd9);
        idle(4);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("s6_clr_count", 32'(count), 32'd0);
        check("s6_clr_busy", 32'(busy), 32'd0);
        idle(3);
        check("s6_clr_pulses", 32'(done_pulses), 32'd0);

        // Randomized control traffic.
        for (int i = 0; i < 3000; i++) begin
            logic             r_st;
            logic             r_pa;
            logic             r_sp;
            logic             r_cl;
            logic [WIDTH-1:0] r_lim;
            r_st  = ($urandom_range(0, 99) < 30);
            r_pa  = ($urandom_range(0, 99) < 15);
            r_sp  = ($urandom_range(0, 99) < 5);
            r_cl  = ($urandom_range(0, 99) < 2);
            r_lim = WIDTH'($urandom_range(0, 15));
            tick(r_st, r_lim, r_pa, r_sp, r_cl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
